// File: rtl/sevseg_updown_counter.sv
// Two debounced push-buttons drive a BCD up/down counter that is time-multiplexed
// onto a common-anode 7-segment display with optional leading-zero blanking.
module sevseg_updown_counter #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_BITS    = 18,
    parameter int WRAP_MODE       = 1,
    parameter int BLANK_LZ        = 1
) (
    input  logic                      clock_50Mhz,
    input  logic                      reset,
    input  logic                      btn_up,
    input  logic                      btn_down,
    output logic [4*NUM_DIGITS-1:0]   count_bcd,
    output logic                      tc_pulse,
    output logic [NUM_DIGITS-1:0]     Anode_Activate,
    output logic [6:0]                LED_SEG
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {RELEASED, PRESSED} db_state_t;

    logic [1:0] btn_raw;
    logic [1:0] btn_event;   // bit 0 = up, bit 1 = down

    assign btn_raw = {btn_down, btn_up};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync_meta, sync_q;
        db_state_t       state, state_nxt;
        logic [DB_W-1:0] stable_cnt, stable_cnt_nxt;
        logic            event_q, event_nxt;

        always_ff @(posedge clock_50Mhz or negedge reset) begin
            if (!reset) begin
                sync_meta  <= 1'b1;
                sync_q     <= 1'b1;
                state      <= RELEASED;
                stable_cnt <= '0;
                event_q    <= 1'b0;
            end else begin
                sync_meta  <= btn_raw[b];
                sync_q     <= sync_meta;
                state      <= state_nxt;
                stable_cnt <= stable_cnt_nxt;
                event_q    <= event_nxt;
            end
        end

        // Counter tracks the run length of the level opposite to the accepted state.
        always_comb begin
            state_nxt      = state;
            stable_cnt_nxt = '0;
            event_nxt      = 1'b0;
            case (state)
                RELEASED: begin
                    if (!sync_q) begin
                        if (stable_cnt == DB_LAST) begin
                            state_nxt = PRESSED;
                            event_nxt = 1'b1;
                        end else begin
                            stable_cnt_nxt = stable_cnt + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (sync_q) begin
                        if (stable_cnt == DB_LAST) begin
                            state_nxt = RELEASED;
                        end else begin
                            stable_cnt_nxt = stable_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = RELEASED;
            endcase
        end

        assign btn_event[b] = event_q;
    end

    logic [4*NUM_DIGITS-1:0] count_nxt;
    logic                    tc_nxt;
    logic                    all_nine, all_zero, carry;

    always_comb begin
        count_nxt = count_bcd;
        tc_nxt    = 1'b0;
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        carry     = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (count_bcd[4*k +: 4] != 4'd9) all_nine = 1'b0;
            if (count_bcd[4*k +: 4] != 4'd0) all_zero = 1'b0;
        end
        if (btn_event[0] && !btn_event[1]) begin
            if (all_nine) begin
                tc_nxt = 1'b1;
                if (WRAP_MODE != 0) count_nxt = '0;
            end else begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (carry) begin
                        if (count_bcd[4*k +: 4] == 4'd9) begin
                            count_nxt[4*k +: 4] = 4'd0;
                        end else begin
                            count_nxt[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
        end else if (btn_event[1] && !btn_event[0]) begin
            if (all_zero) begin
                tc_nxt = 1'b1;
                if (WRAP_MODE != 0) begin
                    for (int unsigned k = 0; k < NUM_DIGITS; k++) count_nxt[4*k +: 4] = 4'd9;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (carry) begin
                        if (count_bcd[4*k +: 4] == 4'd0) begin
                            count_nxt[4*k +: 4] = 4'd9;
                        end else begin
                            count_nxt[4*k +: 4] = count_bcd[4*k +: 4] - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            count_bcd <= '0;
            tc_pulse  <= 1'b0;
        end else begin
            count_bcd <= count_nxt;
            tc_pulse  <= tc_nxt;
        end
    end

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [3:0]              sel_nibble;
    logic                    sel_blank;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [6:0]              seg_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // A digit is a leading zero when it and everything above it are zero.
    always_comb begin
        sel_nibble = '0;
        sel_blank  = 1'b0;
        anode_nxt  = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                anode_nxt[k] = 1'b0;
                sel_nibble   = count_bcd[4*k +: 4];
                sel_blank    = (BLANK_LZ != 0) && (k != 0) && ((count_bcd >> (4*k)) == '0);
            end
        end
        seg_nxt = sel_blank ? 7'b1111111 : seg_decode(sel_nibble);
    end

    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            refresh_cnt    <= '0;
            scan_idx       <= IDX_TOP;
            Anode_Activate <= '1;
            LED_SEG        <= 7'b1111111;
        end else begin
            refresh_cnt    <= refresh_cnt + 1'b1;
            if (&refresh_cnt) begin
                scan_idx <= (scan_idx == '0) ? IDX_TOP : scan_idx - 1'b1;
            end
            Anode_Activate <= anode_nxt;
            LED_SEG        <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_sevseg_updown_counter.sv
// Scoreboard bench: a wrapping 4-digit and a saturating 2-digit counter share the same
// button stimulus; expected counts and display frames come from an arithmetic model.
module tb_sevseg_updown_counter;

    localparam int DB    = 4;
    localparam int DWELL = 4;

    logic clock_50Mhz = 1'b0;
    logic reset = 1'b0;
    logic btn_up = 1'b1;
    logic btn_down = 1'b1;

    logic [15:0] cnt_a;  logic tc_a;  logic [3:0] an_a;  logic [6:0] seg_a;
    logic [7:0]  cnt_b;  logic tc_b;  logic [1:0] an_b;  logic [6:0] seg_b;

    sevseg_updown_counter #(
        .NUM_DIGITS(4), .DEBOUNCE_CYCLES(DB), .REFRESH_BITS(2), .WRAP_MODE(1), .BLANK_LZ(1)
    ) u_dut_wrap (
        .clock_50Mhz(clock_50Mhz), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .count_bcd(cnt_a), .tc_pulse(tc_a), .Anode_Activate(an_a), .LED_SEG(seg_a)
    );

    sevseg_updown_counter #(
        .NUM_DIGITS(2), .DEBOUNCE_CYCLES(DB), .REFRESH_BITS(2), .WRAP_MODE(0), .BLANK_LZ(0)
    ) u_dut_sat (
        .clock_50Mhz(clock_50Mhz), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .count_bcd(cnt_b), .tc_pulse(tc_b), .Anode_Activate(an_b), .LED_SEG(seg_b)
    );

    always #5 clock_50Mhz = ~clock_50Mhz;

    int cyc = 0;
    always @(posedge clock_50Mhz) cyc <= cyc + 1;

    logic [31:0] cnt_w [2];
    logic        tc_w  [2];
    logic [7:0]  an_w  [2];
    logic [6:0]  seg_w [2];
    assign cnt_w[0] = {16'b0, cnt_a};  assign cnt_w[1] = {24'b0, cnt_b};
    assign tc_w[0]  = tc_a;            assign tc_w[1]  = tc_b;
    assign an_w[0]  = {4'b0, an_a};    assign an_w[1]  = {6'b0, an_b};
    assign seg_w[0] = seg_a;           assign seg_w[1] = seg_b;

    typedef struct {
        int t;
        int v;
        bit tc;
    } exp_t;

    exp_t sbq [2][$];
    exp_t dq  [2][$];

    int ndig [2] = '{4, 2};
    bit wrap [2] = '{1'b1, 1'b0};
    bit blz  [2] = '{1'b1, 1'b0};
    int mval [2] = '{0, 0};

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Button model: current raw level, length of its run, accepted level (1 = released).
    bit lvl [2] = '{1'b1, 1'b1};
    int run [2] = '{0, 0};
    bit acc [2] = '{1'b1, 1'b1};

    int rel_cyc = 0;
    int tests = 0;
    int fails = 0;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int k = 0; k < n; k++) begin
            r = r | (32'(x % 10) << (4 * k));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input bit up, input int t);
        exp_t e;
        int   mx;
        for (int id = 0; id < 2; id++) begin
            mx   = pow10(ndig[id]) - 1;
            e.t  = t;
            e.tc = 1'b0;
            e.v  = mval[id];
            if (up) begin
                if (e.v == mx) begin
                    e.tc = 1'b1;
                    e.v  = wrap[id] ? 0 : mx;
                end else e.v = e.v + 1;
            end else begin
                if (e.v == 0) begin
                    e.tc = 1'b1;
                    e.v  = wrap[id] ? mx : 0;
                end else e.v = e.v - 1;
            end
            mval[id] = e.v;
            sbq[id].push_back(e);
            dq[id].push_back(e);
        end
    endtask

    // Holds (u,d) for len clocks; a run of DB samples flips the accepted level and a
    // press shows up on count_bcd 3 clocks after its DB-th raw sample.
    task automatic drive(input bit u, input bit d, input int len);
        int c;
        int r;
        int tev [2];
        bit nl  [2];
        c = cyc;
        nl[0] = u;
        nl[1] = d;
        for (int b = 0; b < 2; b++) begin
            tev[b] = -1;
            r = (lvl[b] == nl[b]) ? run[b] : 0;
            lvl[b] = nl[b];
            if (acc[b] != nl[b] && r + len >= DB) begin
                acc[b] = nl[b];
                if (!nl[b]) tev[b] = c + DB - r + 3;
            end
            run[b] = (r + len > 4 * DB) ? 4 * DB : r + len;
        end
        if (tev[0] >= 0 && tev[1] >= 0) begin
            if (tev[0] < tev[1]) begin
                step(1'b1, tev[0]);
                step(1'b0, tev[1]);
            end else if (tev[1] < tev[0]) begin
                step(1'b0, tev[1]);
                step(1'b1, tev[0]);
            end
        end else if (tev[0] >= 0) begin
            step(1'b1, tev[0]);
        end else if (tev[1] >= 0) begin
            step(1'b0, tev[1]);
        end
        btn_up   = u;
        btn_down = d;
        repeat (len) @(negedge clock_50Mhz);
    endtask

    task automatic press(input bit up_btn, input int n);
        for (int i = 0; i < n; i++) begin
            if (up_btn) drive(1'b0, 1'b1, DB + int'($urandom_range(0, 3)));
            else        drive(1'b1, 1'b0, DB + int'($urandom_range(0, 3)));
            drive(1'b1, 1'b1, DB + int'($urandom_range(0, 3)));
        end
    endtask

    // Entered and left at a falling clock edge; buttons keep their current level.
    task automatic do_reset(input int hold);
        reset = 1'b0;
        #1;
        for (int id = 0; id < 2; id++) begin
            check($sformatf("rst_count%0d", id), cnt_w[id], '0);
            check($sformatf("rst_tc%0d", id), 32'(tc_w[id]), 32'd0);
            check($sformatf("rst_anode%0d", id), 32'(an_w[id]), 32'((1 << ndig[id]) - 1));
            check($sformatf("rst_seg%0d", id), 32'(seg_w[id]), 32'h7f);
            check($sformatf("drain%0d", id), 32'(sbq[id].size()), 32'd0);
            sbq[id].delete();
            dq[id].delete();
            mval[id] = 0;
        end
        repeat (hold) @(negedge clock_50Mhz);
        reset   = 1'b1;
        rel_cyc = cyc;
        lvl[0]  = btn_up;
        lvl[1]  = btn_down;
        for (int b = 0; b < 2; b++) begin
            run[b] = 0;
            acc[b] = 1'b1;
        end
    endtask

    logic [31:0] prev [2] = '{32'd0, 32'd0};

    initial begin : count_monitor
        exp_t e;
        forever begin
            @(negedge clock_50Mhz);
            #1;
            for (int id = 0; id < 2; id++) begin
                if (!reset) begin
                    prev[id] = '0;
                end else begin
                    while (sbq[id].size() > 0 && sbq[id][0].t < cyc) begin
                        e = sbq[id].pop_front();
                        tests++;
                        fails++;
                        $display("FAIL missed_step%0d: got no change, expected %h tc=%0d at cycle %0d",
                                 id, to_bcd(e.v, ndig[id]), e.tc, e.t);
                    end
                    if (cnt_w[id] !== prev[id] || tc_w[id] !== 1'b0) begin
                        if (sbq[id].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_step%0d: got %h tc=%b, expected no change (cycle %0d)",
                                     id, cnt_w[id], tc_w[id], cyc);
                        end else begin
                            e = sbq[id].pop_front();
                            check($sformatf("count%0d", id), cnt_w[id], to_bcd(e.v, ndig[id]));
                            check($sformatf("tc%0d", id), 32'(tc_w[id]), 32'(e.tc));
                            check($sformatf("step_cycle%0d", id), 32'(cyc), 32'(e.t));
                        end
                    end
                    prev[id] = cnt_w[id];
                end
            end
        end
    end

    int vprev [2] = '{0, 0};

    initial begin : display_monitor
        int e_idx, d, dig;
        logic [31:0] exp_an, exp_seg;
        forever begin
            @(negedge clock_50Mhz);
            #1;
            for (int id = 0; id < 2; id++) begin
                if (!reset) begin
                    vprev[id] = 0;
                end else begin
                    e_idx = cyc - rel_cyc;
                    if (e_idx >= 1) begin
                        d       = ndig[id] - 1 - (((e_idx - 1) / DWELL) % ndig[id]);
                        exp_an  = 32'(((1 << ndig[id]) - 1) & ~(1 << d));
                        dig     = (vprev[id] / pow10(d)) % 10;
                        exp_seg = (blz[id] && d > 0 && vprev[id] < pow10(d)) ? 32'h7f : 32'(seg_tab[dig]);
                        check($sformatf("anode%0d", id), 32'(an_w[id]), exp_an);
                        check($sformatf("seg%0d", id), 32'(seg_w[id]), exp_seg);
                    end
                    while (dq[id].size() > 0 && dq[id][0].t <= cyc) vprev[id] = dq[id].pop_front().v;
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clock_50Mhz);
        do_reset(2);

        // one long hold -> one step
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);

        // bouncing contact never reaches a full debounce run
        repeat (10) begin
            drive(1'b0, 1'b1, 3);
            drive(1'b1, 1'b1, 1);
        end
        drive(1'b1, 1'b1, 12);

        // through zero both ways
        press(1'b0, 2);
        press(1'b1, 1);

        // identical timing on both buttons cancels
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b1, 10);

        // saturating counter to its ceiling and past it
        press(1'b1, 101);

        repeat (300) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        drive(1'b1, 1'b1, 20);

        // scan pattern with leading zeros, then reset mid-dwell
        do_reset(3);
        press(1'b1, 42);
        drive(1'b1, 1'b1, 42);

        // button held across reset yields one step after the full debounce time
        drive(1'b0, 1'b1, 3);
        do_reset(2);
        drive(1'b0, 1'b1, 15);
        drive(1'b1, 1'b1, 15);

        for (int id = 0; id < 2; id++) begin
            check($sformatf("final_pending%0d", id), 32'(sbq[id].size()), 32'd0);
            check($sformatf("final_count%0d", id), cnt_w[id], to_bcd(mval[id], ndig[id]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevseg_updown_counter.md
Name: sevseg_updown_counter

Overview:
- Parametrised successor to the single-button 7-segment counter.
- Two debounced push-buttons (up, down) drive a BCD up/down counter of NUM_DIGITS decimal digits.
- Counter behaviour at the limits is selectable: wrap or saturate.
- The value is time-multiplexed onto a common-anode display with optional leading-zero blanking.
- Sits between the raw board buttons and the display pins; BCD value and terminal-count pulse are also exported for other blocks.

Parameters:
NUM_DIGITS, 4, number of decimal digits / anodes (1..8)
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level change (>=2)
REFRESH_BITS, 18, per-digit dwell of 2^REFRESH_BITS clocks
WRAP_MODE, 1, 1 = wrap at limits; 0 = saturate at limits
BLANK_LZ, 1, 1 = blank leading zeros; digit 0 is always shown

Ports:
clock_50Mhz  input  1  system clock
reset  input  1  asynchronous active-low reset
btn_up  input  1  raw up button, active-low, asynchronous to clock
btn_down  input  1  raw down button, active-low, asynchronous to clock
count_bcd  output  4*NUM_DIGITS  current value; nibble k = decimal digit k; k=0 is least significant
tc_pulse  output  1  one-cycle pulse on wrap or on a saturated (rejected) step
Anode_Activate  output  NUM_DIGITS  active-low digit enables; bit k drives digit k
LED_SEG  output  7  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Reset: all state clears asynchronously when reset=0.
  - count_bcd=0, tc_pulse=0.
  - Anode_Activate all 1s, LED_SEG=7'b1111111.
  - Refresh counter=0; scan index=NUM_DIGITS-1.
  - Both debouncers in RELEASED with counters at 0; synchronisers preset to 1.
- Synchroniser: each button passes through a 2-flop synchroniser before its debouncer.
- Debouncer (one FSM per button), states RELEASED / PRESSED:
  - RELEASED: stable counter increments while synced input=0 and clears to 0 when input=1.
  - On reaching DEBOUNCE_CYCLES: go to PRESSED, emit a one-cycle event, clear the counter.
  - PRESSED: same rule with input=1; on reaching DEBOUNCE_CYCLES go to RELEASED with no event.
  - Exactly one event per press, however long the button is held.
  - Latency from raw edge to event: 2 + DEBOUNCE_CYCLES clocks.
- Counter, updated on the cycle after an event:
  - up event: BCD increment with ripple carry through the digits.
  - down event: BCD decrement with ripple borrow.
  - Every nibble stays in 0..9 at all times.
  - Up and down events in the same cycle: no change, no tc_pulse.
- Limit handling, with MAX = all digits 9:
  - up at MAX: WRAP_MODE=1 gives 0 and tc_pulse=1; WRAP_MODE=0 holds MAX and tc_pulse=1.
  - down at 0: WRAP_MODE=1 gives MAX and tc_pulse=1; WRAP_MODE=0 holds 0 and tc_pulse=1.
  - tc_pulse rises in the same cycle as the count update.
- Scan:
  - Free-running refresh counter of REFRESH_BITS bits.
  - Scan index steps down by 1 on each refresh-counter rollover: NUM_DIGITS-1 ... 0, then back to NUM_DIGITS-1.
  - Outputs are registered one clock after the index/count change.
  - Anode_Activate = all 1s except bit[index]=0. LED_SEG = decode of nibble[index].
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value displays blank (1111111).
- Blanking: with BLANK_LZ=1, a digit k>0 shows blank when it and every higher digit are 0. Its anode is still driven, so dwell timing is unchanged.
- Reset mid-press: debouncer returns to RELEASED. A button still held after release of reset generates one event after the full debounce period.

Test Plan:
- Params NUM_DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_BITS=2, WRAP_MODE=1. Apply reset, release, hold btn_up low 20 clocks -> exactly one event; count_bcd=16'h0001 at clock 7 after the edge; no further change while held.
- btn_up bounce: low 3, high 1, low 3, high, repeated for 40 clocks -> count_bcd unchanged, no event.
- Preload to 9999 via 9999 up-presses (or force) -> one more up gives 16'h0000 with tc_pulse high for 1 cycle. Down at 0 gives 16'h9999 with tc_pulse.
- Same as the previous scenario with WRAP_MODE=0 -> up at 9999 stays 9999 with tc_pulse; down at 0 stays 0 with tc_pulse.
- btn_up and btn_down pressed with identical timing -> count unchanged, tc_pulse stays 0.
- count_bcd=16'h0042, BLANK_LZ=1 -> anodes cycle 0111, 1011, 1101, 1110, each held 4 clocks; LED_SEG = 1111111, 1111111, 0011001, 0100100. Assert reset mid-scan -> Anode_Activate=1111 and LED_SEG=1111111 immediately.
